// File: rtl/can_pkg.sv
// Shared CAN constants and types used by the transmit stuffer and the receive destuffer.
package can_pkg;

  localparam int   CAN_STUFF_LEN  = 5;
  localparam logic CAN_RECESSIVE  = 1'b1;
  localparam int   CAN_RUN_CNT_W  = 3;

  typedef enum logic [1:0] {
    TICK_STUFF,
    TICK_DATA_STUFF,
    TICK_DATA_PLAIN,
    TICK_UNDERRUN
  } tick_kind_e;

endpackage

// File: rtl/bit_stuffing.sv
// CAN transmit bit stuffer: one output bit per bit_tick, inserting an opposite bit after a run.
// Optional per-frame stuff-bit counter built when BIT_STUFFING_STATS_EN is defined.
module bit_stuffing
  import can_pkg::*;
#(
  parameter int STUFF_LEN = CAN_STUFF_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_tick,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        stuff_en,
  output logic        bit_ready,
  output logic        bit_out,
  output logic        bit_out_valid,
  output logic        stuff_inserted,
  output logic        error_underrun,
  output logic [15:0] stuff_count
);

  localparam logic [CAN_RUN_CNT_W-1:0] STUFF_LEN_C = CAN_RUN_CNT_W'(STUFF_LEN);

  logic                     last_bit;
  logic [CAN_RUN_CNT_W-1:0] count;
  logic                     initialized;
  logic                     stuff_pending;

  tick_kind_e               kind;
  logic                     emit_bit;
  logic [CAN_RUN_CNT_W-1:0] count_nxt;
  logic [CAN_RUN_CNT_W-1:0] run_len;
  logic                     init_nxt;
  logic                     pend_nxt;

  always_comb begin
    kind      = TICK_UNDERRUN;
    emit_bit  = CAN_RECESSIVE;
    count_nxt = count;
    init_nxt  = initialized;
    pend_nxt  = stuff_pending;
    run_len   = (initialized && (bit_in == last_bit)) ? count + 1'b1 : CAN_RUN_CNT_W'(1);

    if (stuff_pending) begin
      kind = TICK_STUFF;
    end else if (bit_valid) begin
      kind = stuff_en ? TICK_DATA_STUFF : TICK_DATA_PLAIN;
    end

    case (kind)
      TICK_STUFF: begin
        emit_bit  = ~last_bit;
        count_nxt = CAN_RUN_CNT_W'(1);
        pend_nxt  = 1'b0;
      end
      TICK_DATA_STUFF: begin
        emit_bit  = bit_in;
        count_nxt = run_len;
        init_nxt  = 1'b1;
        pend_nxt  = (run_len == STUFF_LEN_C);
      end
      TICK_DATA_PLAIN: begin
        emit_bit  = bit_in;
        count_nxt = '0;
        init_nxt  = 1'b0;
      end
      default: begin
        emit_bit  = CAN_RECESSIVE;
        count_nxt = '0;
        init_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_bit       <= 1'b0;
      count          <= '0;
      initialized    <= 1'b0;
      stuff_pending  <= 1'b0;
      bit_ready      <= 1'b1;
      bit_out        <= CAN_RECESSIVE;
      bit_out_valid  <= 1'b0;
      stuff_inserted <= 1'b0;
      error_underrun <= 1'b0;
    end else begin
      bit_out_valid  <= bit_tick;
      stuff_inserted <= bit_tick && (kind == TICK_STUFF);
      error_underrun <= bit_tick && (kind == TICK_UNDERRUN);
      if (bit_tick) begin
        bit_out       <= emit_bit;
        last_bit      <= emit_bit;
        count         <= count_nxt;
        initialized   <= init_nxt;
        stuff_pending <= pend_nxt;
        bit_ready     <= ~pend_nxt;
      end
    end
  end

`ifdef BIT_STUFFING_STATS_EN
  logic        prev_stuff_en;
  logic [15:0] stuff_count_q;

  // A consumed stuffing-window bit after a non-window bit marks a new frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_stuff_en <= 1'b0;
      stuff_count_q <= '0;
    end else if (bit_tick) begin
      if (kind == TICK_STUFF) begin
        if (stuff_count_q != 16'hFFFF) stuff_count_q <= stuff_count_q + 16'd1;
      end else if ((kind == TICK_DATA_STUFF) || (kind == TICK_DATA_PLAIN)) begin
        prev_stuff_en <= stuff_en;
        if ((kind == TICK_DATA_STUFF) && !prev_stuff_en) stuff_count_q <= '0;
      end
    end
  end

  assign stuff_count = stuff_count_q;
`else
  assign stuff_count = '0;
`endif

endmodule

// File: tb/tb_bit_stuffing.sv
// Self-checking bench for bit_stuffing: directed vector table, reset corner, randomized run vs model.
module tb_bit_stuffing;

  localparam int STUFF_LEN = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_tick;
  logic        bit_in;
  logic        bit_valid;
  logic        stuff_en;
  logic        bit_ready;
  logic        bit_out;
  logic        bit_out_valid;
  logic        stuff_inserted;
  logic        error_underrun;
  logic [15:0] stuff_count;

  bit_stuffing #(.STUFF_LEN(STUFF_LEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .bit_tick       (bit_tick),
    .bit_in         (bit_in),
    .bit_valid      (bit_valid),
    .stuff_en       (stuff_en),
    .bit_ready      (bit_ready),
    .bit_out        (bit_out),
    .bit_out_valid  (bit_out_valid),
    .stuff_inserted (stuff_inserted),
    .error_underrun (error_underrun),
    .stuff_count    (stuff_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic b, v, s;
    logic eo, es, eu, er;
  } vec_t;

  vec_t vecs[$];

  // Reference model: the current run is the list of identical emitted bits since it began.
  logic        run_q[$];
  logic        m_pend;
  logic        m_last;
  logic        m_prev_sen;
  logic [15:0] m_cnt;

  function automatic logic [15:0] exp_count();
`ifdef BIT_STUFFING_STATS_EN
    return m_cnt;
`else
    return 16'd0;
`endif
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    run_q.delete();
    m_pend = 1'b0;
    m_last = 1'b0;
    m_prev_sen = 1'b0;
    m_cnt = 16'd0;
  endtask

  task automatic model_step(input logic b, input logic v, input logic s,
                            output logic eo, output logic es, output logic eu, output logic er);
    es = 1'b0;
    eu = 1'b0;
    if (m_pend) begin
      eo = ~m_last;
      es = 1'b1;
      m_pend = 1'b0;
      run_q.delete();
      run_q.push_back(eo);
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (v) begin
      eo = b;
      if (s) begin
        if (!m_prev_sen) m_cnt = 16'd0;
        if (run_q.size() > 0 && run_q[run_q.size()-1] != b) run_q.delete();
        run_q.push_back(b);
        if (run_q.size() == STUFF_LEN) m_pend = 1'b1;
      end else begin
        run_q.delete();
      end
      m_prev_sen = s;
    end else begin
      eo = 1'b1;
      eu = 1'b1;
      run_q.delete();
    end
    m_last = eo;
    er = ~m_pend;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bit_tick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    check("rst_bit_out", 16'(bit_out), 16'd1);
    check("rst_bit_ready", 16'(bit_ready), 16'd1);
    check("rst_valid", 16'(bit_out_valid), 16'd0);
    check("rst_stuff", 16'(stuff_inserted), 16'd0);
    check("rst_underrun", 16'(error_underrun), 16'd0);
    check("rst_count", stuff_count, 16'd0);
  endtask

  // Drive one tick (after optional idle cycles) and sample one half-cycle after its edge.
  task automatic tick(input logic b, input logic v, input logic s, input int gap,
                      output logic ao, output logic as_, output logic au, output logic ar);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    check("idle_valid", 16'(bit_out_valid), 16'd0);
    check("idle_stuff", 16'(stuff_inserted), 16'd0);
    bit_in = b;
    bit_valid = v;
    stuff_en = s;
    bit_tick = 1'b1;
    @(negedge clk);
    bit_tick = 1'b0;
    check("out_valid", 16'(bit_out_valid), 16'd1);
    ao = bit_out;
    as_ = stuff_inserted;
    au = error_underrun;
    ar = bit_ready;
  endtask

  function automatic void add(input logic b, input logic v, input logic s,
                              input logic eo, input logic es, input logic eu, input logic er,
                              input int reps);
    vec_t t;
    t = '{b: b, v: v, s: s, eo: eo, es: es, eu: eu, er: er};
    for (int i = 0; i < reps; i++) vecs.push_back(t);
  endfunction

  initial begin
    logic ao, as_, au, ar;
    logic eo, es, eu, er;
    logic rb, rs;

    rst = 1'b0;
    bit_tick = 1'b0;
    bit_in = 1'b0;
    bit_valid = 1'b0;
    stuff_en = 1'b0;
    do_reset();

    // 0,0,0,0,0,1 in the window: stuff 1 after the fifth 0, then the data 1.
    add(0,1,1, 0,0,0,1, 4);
    add(0,1,1, 0,0,0,0, 1);
    add(1,1,1, 1,1,0,1, 1);
    add(1,1,1, 1,0,0,1, 1);
    // Window closes right after a run of five 1s: the owed stuff 0 still goes out.
    add(0,1,0, 0,0,0,1, 1);
    add(1,1,1, 1,0,0,1, 4);
    add(1,1,1, 1,0,0,0, 1);
    add(1,1,0, 0,1,0,1, 1);
    add(1,1,0, 1,0,0,1, 2);
    // Underrun restarts the run; the stuff tick ignores a low bit_valid.
    add(0,0,1, 1,0,1,1, 1);
    add(0,1,1, 0,0,0,1, 4);
    add(0,1,1, 0,0,0,0, 1);
    add(0,0,1, 1,1,0,1, 1);
    // Outside the window nothing is stuffed.
    add(1,1,0, 1,0,0,1, 8);
    // Ten 0s in the window -> 0000010000 01.
    add(0,1,1, 0,0,0,1, 4);
    add(0,1,1, 0,0,0,0, 1);
    add(0,1,1, 1,1,0,1, 1);
    add(0,1,1, 0,0,0,1, 4);
    add(0,1,1, 0,0,0,0, 1);
    add(0,0,0, 1,1,0,1, 1);

    foreach (vecs[i]) begin
      tick(vecs[i].b, vecs[i].v, vecs[i].s, i % 3, ao, as_, au, ar);
      model_step(vecs[i].b, vecs[i].v, vecs[i].s, eo, es, eu, er);
      check($sformatf("vec%0d_out", i), 16'(ao), 16'(vecs[i].eo));
      check($sformatf("vec%0d_stuff", i), 16'(as_), 16'(vecs[i].es));
      check($sformatf("vec%0d_underrun", i), 16'(au), 16'(vecs[i].eu));
      check($sformatf("vec%0d_ready", i), 16'(ar), 16'(vecs[i].er));
      check($sformatf("vec%0d_count", i), stuff_count, exp_count());
    end

    // Reset while a stuff bit is owed: it must be dropped.
    for (int i = 0; i < STUFF_LEN; i++) begin
      tick(1'b0, 1'b1, 1'b1, 0, ao, as_, au, ar);
      model_step(1'b0, 1'b1, 1'b1, eo, es, eu, er);
    end
    check("pend_ready_low", 16'(bit_ready), 16'd0);
    do_reset();
    tick(1'b0, 1'b1, 1'b1, 1, ao, as_, au, ar);
    model_step(1'b0, 1'b1, 1'b1, eo, es, eu, er);
    check("post_rst_out", 16'(ao), 16'd0);
    check("post_rst_stuff", 16'(as_), 16'd0);
    check("post_rst_ready", 16'(ar), 16'd1);

    // Randomized frames with runs, window toggling and occasional underruns.
    rb = 1'b0;
    rs = 1'b1;
    for (int i = 0; i < 600; i++) begin
      logic rv;
      if ($urandom_range(0, 3) == 0) rb = ~rb;
      if ($urandom_range(0, 15) == 0) rs = ~rs;
      rv = ($urandom_range(0, 11) != 0);
      tick(rb, rv, rs, $urandom_range(0, 2), ao, as_, au, ar);
      model_step(rb, rv, rs, eo, es, eu, er);
      check("rnd_out", 16'(ao), 16'(eo));
      check("rnd_stuff", 16'(as_), 16'(es));
      check("rnd_underrun", 16'(au), 16'(eu));
      check("rnd_ready", 16'(ar), 16'(er));
      check("rnd_count", stuff_count, exp_count());
    end

    @(negedge clk);
    check("final_valid_idle", 16'(bit_out_valid), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
